marcador_juego: RTL and testbench

Score/timing companion to the LED reaction-game controller: it consumes the controller's score-modify pulses and LED status, and returns GanadorA/GanadorB, the Apagar LED-timeout pulse and the Random bit. It keeps both players' scores, applies reward/penalty rules, detects the winner and exposes the scores for display. It sits beside the controller and shares the same game clock.

---
 rtl/marcador_juego.sv | 196 +++++++++++++++++++
 tb/tb_marcador_juego.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/marcador_juego.sv
`default_nettype none
// ============================================================================
//  Module   : marcador_juego
//  Purpose  : Score and timing companion to the LED reaction-game controller.
//             Keeps both players' scores and applies the reward/penalty rules.
//             Detects the winner (or a draw), raises the LED-on timeout pulse
//             and supplies a pseudo-random bit from an 8-bit LFSR.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   game clock, rising edge
//    Reset        in   asynchronous, active-high reset
//    Modo         in   1 = game running
//    ModifA/B     in   one-cycle press pulses for player A / B
//    LedEncendido in   1 = target LED currently lit
//    GanadorA/B   out  winner flags, held while the game is over
//    Apagar       out  one-cycle LED-on timeout pulse
//    Random       out  LFSR bit 0
//    PuntosA/B    out  player scores
// ============================================================================
module marcador_juego #(
    parameter int unsigned SCORE_W   = 4,
    parameter int unsigned WIN_SCORE = 5,
    parameter int unsigned ON_TICKS  = 1000,
    parameter int unsigned TIMER_W   = 10,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic               clock,
    input  logic               Reset,
    input  logic               Modo,
    input  logic               ModifA,
    input  logic               ModifB,
    input  logic               LedEncendido,
    output logic               GanadorA,
    output logic               GanadorB,
    output logic               Apagar,
    output logic               Random,
    output logic [SCORE_W-1:0] PuntosA,
    output logic [SCORE_W-1:0] PuntosB
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_JUEGO = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    localparam logic [SCORE_W-1:0] C_WIN = SCORE_W'(WIN_SCORE);
    // The timer is loaded with the full tick count on the LED rise edge and
    // Apagar is issued on the edge where it leaves 1, so the pulse appears
    // ON_TICKS edges after the edge that saw the LED come on.
    localparam logic [TIMER_W-1:0] C_TIMER_LOAD = TIMER_W'(ON_TICKS);
    localparam logic [TIMER_W-1:0] C_TIMER_ONE  = TIMER_W'(1);

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   puntos_a_q, puntos_a_d;
    logic [SCORE_W-1:0]   puntos_b_q, puntos_b_d;
    logic                 ganador_a_q, ganador_a_d;
    logic                 ganador_b_q, ganador_b_d;
    logic                 apagar_q, apagar_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic                 modo_q;
    logic                 led_q;

    logic [SCORE_W-1:0]   score_a_next;
    logic [SCORE_W-1:0]   score_b_next;
    logic                 win_a;
    logic                 win_b;

    // Reward a lit press, penalise an early press (saturating at zero).
    function automatic logic [SCORE_W-1:0] f_score(
        input logic [SCORE_W-1:0] cur,
        input logic               press,
        input logic               lit
    );
        logic [SCORE_W-1:0] res;
        res = cur;
        if (press) begin
            if (lit) begin
                res = cur + SCORE_W'(1);
            end else if (cur != '0) begin
                res = cur - SCORE_W'(1);
            end
        end
        return res;
    endfunction

    always_comb begin
        score_a_next = f_score(puntos_a_q, ModifA, LedEncendido);
        score_b_next = f_score(puntos_b_q, ModifB, LedEncendido);
        win_a        = (score_a_next == C_WIN);
        win_b        = (score_b_next == C_WIN);
    end

    // Fibonacci LFSR, taps 8,6,5,4; free-running in every state.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_comb begin
        state_d     = state_q;
        puntos_a_d  = puntos_a_q;
        puntos_b_d  = puntos_b_q;
        ganador_a_d = ganador_a_q;
        ganador_b_d = ganador_b_q;
        apagar_d    = 1'b0;
        timer_d     = timer_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (Modo && !modo_q) begin
                    puntos_a_d = '0;
                    puntos_b_d = '0;
                    state_d    = S_JUEGO;
                end
            end

            S_JUEGO: begin
                if (!Modo) begin
                    // Abandoned game: no winner, scores stay for display.
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    puntos_a_d = score_a_next;
                    puntos_b_d = score_b_next;
                    if (win_a || win_b) begin
                        // Both flags may rise together on a draw.
                        state_d     = S_FIN;
                        ganador_a_d = win_a;
                        ganador_b_d = win_b;
                        timer_d     = '0;
                    end else if (ModifA || ModifB || !LedEncendido) begin
                        // Any press or the LED going dark cancels the timeout.
                        timer_d = '0;
                    end else if (!led_q) begin
                        timer_d = C_TIMER_LOAD;
                    end else if (timer_q != '0) begin
                        timer_d  = timer_q - C_TIMER_ONE;
                        apagar_d = (timer_q == C_TIMER_ONE);
                    end
                end
            end

            S_FIN: begin
                timer_d = '0;
                if (!Modo) begin
                    state_d     = S_IDLE;
                    ganador_a_d = 1'b0;
                    ganador_b_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            puntos_a_q  <= '0;
            puntos_b_q  <= '0;
            ganador_a_q <= 1'b0;
            ganador_b_q <= 1'b0;
            apagar_q    <= 1'b0;
            timer_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            modo_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            puntos_a_q  <= puntos_a_d;
            puntos_b_q  <= puntos_b_d;
            ganador_a_q <= ganador_a_d;
            ganador_b_q <= ganador_b_d;
            apagar_q    <= apagar_d;
            timer_q     <= timer_d;
            lfsr_q      <= lfsr_d;
            modo_q      <= Modo;
            led_q       <= LedEncendido;
        end
    end

    assign GanadorA = ganador_a_q;
    assign GanadorB = ganador_b_q;
    assign Apagar   = apagar_q;
    assign Random   = lfsr_q[0];
    assign PuntosA  = puntos_a_q;
    assign PuntosB  = puntos_b_q;

endmodule
`default_nettype wire

// File: tb/tb_marcador_juego.sv
`default_nettype none
// ============================================================================
//  Module   : tb_marcador_juego
//  Purpose  : Self-checking bench for marcador_juego with a behavioural model
//             (game phase, scores, "edges since LED lit" counter, LFSR).
//  Revision : 1.0  initial release
// ============================================================================
module tb_marcador_juego;

    localparam int SW  = 4;
    localparam int WIN = 3;
    localparam int ON  = 4;
    localparam int TW  = 3;

    logic clock = 1'b0;
    logic Reset = 1'b1;
    logic Modo = 1'b0, ModifA = 1'b0, ModifB = 1'b0, LedEncendido = 1'b0;
    logic GanadorA, GanadorB, Apagar, Random;
    logic [SW-1:0] PuntosA, PuntosB;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    marcador_juego #(
        .SCORE_W  (SW),
        .WIN_SCORE(WIN),
        .ON_TICKS (ON),
        .TIMER_W  (TW),
        .LFSR_SEED(8'hA5)
    ) dut (
        .clock       (clock),
        .Reset       (Reset),
        .Modo        (Modo),
        .ModifA      (ModifA),
        .ModifB      (ModifB),
        .LedEncendido(LedEncendido),
        .GanadorA    (GanadorA),
        .GanadorB    (GanadorB),
        .Apagar      (Apagar),
        .Random      (Random),
        .PuntosA     (PuntosA),
        .PuntosB     (PuntosB)
    );

    // ---------------- behavioural model ----------------
    // phase: 0 = waiting, 1 = playing, 2 = game over
    int       m_phase = 0;
    int       m_a = 0, m_b = 0;
    bit       m_ga = 0, m_gb = 0, m_ap = 0;
    bit [7:0] m_lfsr = 8'hA5;
    bit       m_modo_p = 0, m_led_p = 0;
    bit       m_armed = 0;
    int       m_age = 0;

    always @(posedge clock or posedge Reset) begin
        if (Reset) begin
            m_phase = 0; m_a = 0; m_b = 0; m_ga = 0; m_gb = 0; m_ap = 0;
            m_lfsr = 8'hA5; m_modo_p = 0; m_led_p = 0; m_armed = 0; m_age = 0;
        end else begin
            m_ap   = 0;
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            case (m_phase)
                0: if (Modo && !m_modo_p) begin m_a = 0; m_b = 0; m_phase = 1; end
                1: begin
                    if (!Modo) begin
                        m_phase = 0; m_armed = 0;
                    end else begin
                        if (ModifA) m_a = LedEncendido ? m_a + 1 : (m_a > 0 ? m_a - 1 : 0);
                        if (ModifB) m_b = LedEncendido ? m_b + 1 : (m_b > 0 ? m_b - 1 : 0);
                        if (m_a == WIN || m_b == WIN) begin
                            m_phase = 2; m_ga = (m_a == WIN); m_gb = (m_b == WIN); m_armed = 0;
                        end else if (ModifA || ModifB || !LedEncendido) begin
                            m_armed = 0;
                        end else if (!m_led_p) begin
                            m_armed = 1; m_age = 0;
                        end else if (m_armed) begin
                            m_age++;
                            if (m_age == ON) begin m_ap = 1; m_armed = 0; end
                        end
                    end
                end
                default: if (!Modo) begin m_phase = 0; m_ga = 0; m_gb = 0; end
            endcase
            m_modo_p = Modo;
            m_led_p  = LedEncendido;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clock) begin
        checks++;
        if (GanadorA !== m_ga || GanadorB !== m_gb || Apagar !== m_ap ||
            Random !== m_lfsr[0] || int'(PuntosA) != m_a || int'(PuntosB) != m_b) begin
            errors++;
            $display("FAIL cycle_model t=%0t got GA=%b GB=%b Ap=%b R=%b PA=%0d PB=%0d exp GA=%b GB=%b Ap=%b R=%b PA=%0d PB=%0d",
                     $time, GanadorA, GanadorB, Apagar, Random, PuntosA, PuntosB,
                     m_ga, m_gb, m_ap, m_lfsr[0], m_a, m_b);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit a, input bit b, input bit led, input bit modo);
        @(negedge clock);
        #1;
        ModifA = a; ModifB = b; LedEncendido = led; Modo = modo;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // model self-pin: LFSR period from the seed
        begin
            bit [7:0] l;
            int n;
            l = 8'hA5;
            n = 0;
            do begin
                l = {l[6:0], ^(l & 8'hB8)};
                n++;
            end while (l != 8'hA5 && n < 1000);
            chk("lfsr_period", n, 255);
        end

        repeat (2) @(posedge clock);
        #1;
        chk("rst_GA", GanadorA, 0);
        chk("rst_PA", PuntosA, 0);
        chk("rst_Random", Random, 1);
        Reset = 1'b0;

        // after reset: first two Random values are 0 then 1
        @(posedge clock); #1; chk("rand_edge1", Random, 0);
        @(posedge clock); #1; chk("rand_edge2", Random, 1);

        // scoring and A win
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(1, 0, 1, 1); chk("A_pts1", PuntosA, 1);
        step(0, 0, 1, 1);
        step(1, 0, 1, 1); chk("A_pts2", PuntosA, 2);
        step(0, 0, 1, 1);
        step(1, 0, 1, 1); chk("A_pts3", PuntosA, 3); chk("A_win", GanadorA, 1);
        step(1, 0, 1, 1); chk("A_fin_hold", PuntosA, 3);
        step(0, 0, 1, 0); chk("A_exit_gan", GanadorA, 0); chk("A_exit_pts", PuntosA, 3);

        // penalty
        step(0, 0, 0, 1);
        step(0, 1, 0, 1); chk("B_sat0", PuntosB, 0);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1); chk("B_pts2", PuntosB, 2);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1); chk("B_pen1", PuntosB, 1);
        step(0, 0, 0, 0);

        // timeout
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        for (int i = 1; i < ON; i++) begin step(0, 0, 1, 1); chk("tmo_early", Apagar, 0); end
        step(0, 0, 1, 1); chk("tmo_fire", Apagar, 1);
        step(0, 0, 1, 1); chk("tmo_once", Apagar, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin step(0, 0, 0, 1); chk("tmo_ledoff", Apagar, 0); end
        step(0, 0, 1, 1);
        step(1, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin step(0, 0, 1, 1); chk("tmo_press", Apagar, 0); end
        step(0, 0, 0, 0);

        // draw
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(1, 1, 1, 1);
        step(0, 0, 1, 1);
        step(1, 1, 1, 1);
        step(0, 0, 1, 1);
        step(1, 1, 1, 1);
        chk("draw_PA", PuntosA, 3); chk("draw_PB", PuntosB, 3);
        chk("draw_GA", GanadorA, 1); chk("draw_GB", GanadorB, 1);
        step(1, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1);
            chk("fin_PA", PuntosA, 3); chk("fin_GB", GanadorB, 1); chk("fin_Ap", Apagar, 0);
        end

        // asynchronous reset mid-cycle while in the finished state
        @(posedge clock);
        #2 Reset = 1'b1;
        #1;
        chk("arst_GA", GanadorA, 0); chk("arst_GB", GanadorB, 0);
        chk("arst_PA", PuntosA, 0); chk("arst_PB", PuntosB, 0);
        chk("arst_Ap", Apagar, 0); chk("arst_Random", Random, 1);
        #1 Reset = 1'b0;
        @(posedge clock); #1; chk("arst_rand1", Random, 0);
        @(posedge clock); #1; chk("arst_rand2", Random, 1);
        step(0, 0, 0, 0);
        repeat (300) @(posedge clock);

        // abandon mid-game
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 0, 1, 0);
        chk("abn_GA", GanadorA, 0); chk("abn_GB", GanadorB, 0);
        chk("abn_PA", PuntosA, 1); chk("abn_PB", PuntosB, 2);
        step(0, 0, 0, 1);
        chk("new_PA", PuntosA, 0); chk("new_PB", PuntosB, 0);

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            #1;
            if ($urandom_range(0, 29) == 0) Modo = ~Modo;
            if ($urandom_range(0, 5) == 0) LedEncendido = ~LedEncendido;
            ModifA = ($urandom_range(0, 6) == 0);
            ModifB = ($urandom_range(0, 6) == 0);
            @(posedge clock);
            if ($urandom_range(0, 499) == 0) begin
                #2 Reset = 1'b1;
                #2 Reset = 1'b0;
            end
        end

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
